instr_prefetch: RTL and testbench

//  Instruction prefetch queue directly upstream of the 16-bit cpu core; drives its 'instruction' input.

---
 rtl/instr_prefetch_if.sv | 13 +
 rtl/instr_prefetch.sv | 138 +++++++++++++
 tb/tb_instr_prefetch.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_if.sv
// rtl/instr_prefetch_if.sv - instruction memory read bus (req/ack) between prefetch queue and memory
interface instr_prefetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - instruction prefetch queue tracking cpu pc; optional PREFETCH_FLUSH_CNT_EN adds flush_count
module instr_prefetch #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic [DATA_W-1:0]  instruction,
    output logic               instr_valid,
    instr_prefetch_if.master   mem
`ifdef PREFETCH_FLUSH_CNT_EN
    ,
    output logic [15:0]        flush_count
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_word [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count, count_n;
    logic [ADDR_W-1:0] fptr, fptr_n, head_addr, addr_n;
    logic              req_n, flush, pop, push;

    assign head_addr   = q_addr[rd_ptr];
    assign instr_valid = (count != '0) && (head_addr == pc);
    assign instruction = instr_valid ? q_word[rd_ptr] : '0;

    // With an empty queue, a pc already being fetched is not a jump.
    always_comb begin
        flush = 1'b0;
        pop   = 1'b0;
        if (count != '0) begin
            if (head_addr != pc) begin
                if (pc == head_addr + ONE) pop = 1'b1;
                else                       flush = 1'b1;
            end
        end else begin
            flush = (pc != fptr) && !((state == REQ) && (pc == mem.mem_addr));
        end
        push    = (state == REQ) && mem.mem_ack && !flush;
        count_n = flush ? '0 : count + CW'(push) - CW'(pop);
        fptr_n  = flush ? pc : (push ? fptr + ONE : fptr);
    end

    always_comb begin
        state_n = state;
        req_n   = mem.mem_req;
        addr_n  = mem.mem_addr;
        case (state)
            IDLE: begin
                if (count_n < DEPTH_C) begin
                    state_n = REQ;
                    req_n   = 1'b1;
                    addr_n  = fptr_n;
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    if (!flush && (count_n < DEPTH_C)) begin
                        addr_n = fptr_n;
                    end else begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                    end
                end else if (flush) begin
                    state_n = DROP;
                end
            end
            DROP: begin
                // The abandoned word arrives; restart straight from the new fetch pointer.
                if (mem.mem_ack) begin
                    if (count_n < DEPTH_C) begin
                        state_n = REQ;
                        req_n   = 1'b1;
                        addr_n  = fptr_n;
                    end else begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            count        <= '0;
            fptr         <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
        end else begin
            state        <= state_n;
            mem.mem_req  <= req_n;
            mem.mem_addr <= addr_n;
            count        <= count_n;
            fptr         <= fptr_n;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= mem.mem_addr;
            q_word[wr_ptr] <= mem.mem_rdata;
        end
    end

`ifdef PREFETCH_FLUSH_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            flush_count <= '0;
        else if (flush && (flush_count != 16'hFFFF))
            flush_count <= flush_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_instr_prefetch.sv
// tb/tb_instr_prefetch.sv - directed and randomized checks of instr_prefetch against a cpu/memory reference model
module tb_instr_prefetch;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc = '0;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        ack_en = 1'b1;
`ifdef PREFETCH_FLUSH_CNT_EN
    logic [15:0] flush_count;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    instr_prefetch_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    assign bus.mem_ack   = bus.mem_req & ack_en;
    assign bus.mem_rdata = ref_word(bus.mem_addr);

    instr_prefetch #(.DEPTH(4), .ADDR_W(16), .DATA_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .mem         (bus)
`ifdef PREFETCH_FLUSH_CNT_EN
        ,
        .flush_count (flush_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_word(input logic [15:0] a);
        return 16'(a + 16'h8000);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        pc     = '0;
        ack_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int req_seen;
        logic [15:0] last_addr;
        logic [15:0] hold_addr;
        bit wait_prev;
        int stall;
        int delivered;
        int r;

        // Reset state
        @(negedge clk);
        check_eq("rst_req", bus.mem_req, 0);
        check_eq("rst_addr", bus.mem_addr, 0);
        check_eq("rst_valid", instr_valid, 0);
        check_eq("rst_instr", instruction, 0);
        do_reset();

        // First word two edges after release, then exactly DEPTH requests while pc stalls
        req_seen  = 0;
        last_addr = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check_eq("t1_req", bus.mem_req, 1);
                check_eq("t1_addr", bus.mem_addr, 0);
                check_eq("t1_valid_early", instr_valid, 0);
            end
            if (i == 1) begin
                check_eq("t1_valid", instr_valid, 1);
                check_eq("t1_instr", instruction, 16'h8000);
            end
            if (bus.mem_req) begin
                req_seen++;
                last_addr = bus.mem_addr;
            end
        end
        check_eq("t2_req_count", req_seen, 4);
        check_eq("t2_last_addr", last_addr, 3);
        check_eq("t2_req_idle", bus.mem_req, 0);
        for (int k = 1; k <= 3; k++) begin
            pc = 16'(k);
            @(negedge clk);
            check_eq("t2_step_valid", instr_valid, 1);
            check_eq("t2_step_instr", instruction, ref_word(16'(k)));
        end

        // Jump with a full queue
        do_reset();
        repeat (6) @(negedge clk);
        pc = 16'h0040;
        @(negedge clk);
        check_eq("t3_addr", bus.mem_addr, 16'h0040);
        check_eq("t3_req", bus.mem_req, 1);
        check_eq("t3_flushed", instr_valid, 0);
        @(negedge clk);
        check_eq("t3_valid", instr_valid, 1);
        check_eq("t3_instr", instruction, 16'h8040);

        // Jump while a request waits three cycles for ack
        ack_en = 1'b0;
        pc     = 16'h0100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t4_hold_req", bus.mem_req, 1);
            check_eq("t4_hold_addr", bus.mem_addr, 16'h0041);
        end
        ack_en = 1'b1;
        @(negedge clk);
        check_eq("t4_new_addr", bus.mem_addr, 16'h0100);
        check_eq("t4_dropped", instr_valid, 0);
        @(negedge clk);
        check_eq("t4_valid", instr_valid, 1);
        check_eq("t4_instr", instruction, 16'h8100);

        // Address wrap is sequential
        pc = 16'hFFFF;
        repeat (3) @(negedge clk);
        check_eq("t5_valid", instr_valid, 1);
        check_eq("t5_instr", instruction, 16'h7FFF);
        check_eq("t5_wrap_addr", bus.mem_addr, 16'h0000);
        pc = 16'h0000;
        @(negedge clk);
        check_eq("t5_seq_valid", instr_valid, 1);
        check_eq("t5_seq_instr", instruction, 16'h8000);

`ifdef PREFETCH_FLUSH_CNT_EN
        do_reset();
        for (int j = 1; j <= 3; j++) begin
            pc = 16'(j * 16);
            repeat (3) @(negedge clk);
        end
        check_eq("t6_flush_count", flush_count, 3);
        check_eq("t6_req_before", bus.mem_req, 1);
        reset = 1'b1;
        #1;
        check_eq("t6_rst_req", bus.mem_req, 0);
        check_eq("t6_rst_count", flush_count, 0);
`endif

        // Random cpu: advances on valid, jumps at random; memory acks at random
        do_reset();
        wait_prev = 1'b0;
        hold_addr = '0;
        stall     = 0;
        delivered = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (wait_prev) begin
                check_eq("rnd_req_hold", bus.mem_req, 1);
                check_eq("rnd_addr_hold", bus.mem_addr, hold_addr);
            end
            if (instr_valid) begin
                check_eq("rnd_word", instruction, ref_word(pc));
                delivered++;
                stall = 0;
                r = $urandom_range(99);
                if (r < 80)      pc = 16'(pc + 16'd1);
                else if (r < 90) pc = 16'($urandom);
            end else begin
                check_eq("rnd_invalid_zero", instruction, 0);
                stall++;
                check_eq("rnd_stall_bound", stall > 40, 0);
                if (stall > 40) stall = 0;
                if ($urandom_range(99) < 5) begin
                    pc    = 16'($urandom);
                    stall = 0;
                end
            end
            ack_en    = ($urandom_range(99) < 60);
            wait_prev = bus.mem_req && !ack_en;
            hold_addr = bus.mem_addr;
        end
        check_eq("rnd_throughput", delivered >= 500, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
